mc_ctrl: RTL and testbench

- Multicycle main-control FSM for the MIPS-subset CPU; sequences the datapath one instruction at a time.
- Drives the next-PC unit's `turn`, `branch` and `jump` selects, plus the PC, IR, register-file, ALU and data-memory enables.
- Decodes `opcode`/`funct` from the IR output and waits on a data-memory ready handshake.
- Exactly one PC write (`pcwr`) per instruction, in that instruction's final state; the next-PC unit computes from the un-updated PC.

---
 rtl/mc_ctrl_pkg.sv | 91 +++++++++
 rtl/mc_decode.sv | 25 ++
 rtl/mc_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle main-control FSM: next-PC selects,
// ALU operations, opcodes/functs, FSM state codes and the decoded
// instruction class handed from mc_decode to mc_ctrl.
package mc_ctrl_pkg;

  // Next-PC branch select
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_BGTZ = 2'b11;

  // Next-PC jump select
  localparam logic [1:0] JP_NONE = 2'b00;
  localparam logic [1:0] JP_J    = 2'b01;
  localparam logic [1:0] JP_JAL  = 2'b10;
  localparam logic [1:0] JP_JR   = 2'b11;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;

  // Opcodes
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type functs
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // FSM state encodings
  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_EXE_R  = 4'd2;
  localparam logic [3:0] ST_EXE_I  = 4'd3;
  localparam logic [3:0] ST_MADDR  = 4'd4;
  localparam logic [3:0] ST_MRD    = 4'd5;
  localparam logic [3:0] ST_MWR    = 4'd6;
  localparam logic [3:0] ST_WB_MEM = 4'd7;
  localparam logic [3:0] ST_BR     = 4'd8;
  localparam logic [3:0] ST_JR     = 4'd9;
  localparam logic [3:0] ST_WB_R   = 4'd10;
  localparam logic [3:0] ST_WB_I   = 4'd11;
  localparam logic [3:0] ST_ILL    = 4'd12;

  typedef enum logic [3:0] {
    CL_R, CL_JR, CL_ALUI, CL_LW, CL_SW, CL_BR, CL_J, CL_JAL, CL_ILL
  } instr_class_e;

  // R-type ALU op; unknown functs fall back to ADD
  function automatic logic [2:0] alu_rtype(input logic [5:0] fn);
    case (fn)
      FN_SUBU: return ALU_SUB;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Immediate-form ALU op (addiu/ori/lui)
  function automatic logic [2:0] alu_itype(input logic [5:0] op);
    case (op)
      OP_ORI:  return ALU_OR;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

  // Branch condition handed to the next-PC unit
  function automatic logic [1:0] branch_sel(input logic [5:0] op);
    case (op)
      OP_BEQ:  return BR_BEQ;
      OP_BNE:  return BR_BNE;
      OP_BGTZ: return BR_BGTZ;
      default: return BR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct classifier feeding the control FSM.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   i_opcode,
  input  logic [5:0]   i_funct,
  output instr_class_e o_class
);

  // Map the IR fields to one of the instruction classes the FSM sequences
  always_comb begin
    o_class = CL_ILL;
    case (i_opcode)
      OP_R:                     o_class = (i_funct == FN_JR) ? CL_JR : CL_R;
      OP_ADDIU, OP_ORI, OP_LUI: o_class = CL_ALUI;
      OP_LW:                    o_class = CL_LW;
      OP_SW:                    o_class = CL_SW;
      OP_BEQ, OP_BNE, OP_BGTZ:  o_class = CL_BR;
      OP_J:                     o_class = CL_J;
      OP_JAL:                   o_class = CL_JAL;
      default:                  o_class = CL_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle main-control FSM: sequences fetch/decode/execute/memory/
// writeback for one instruction at a time, issuing exactly one PC write in
// each instruction's final state. Outputs are forced to 0 during reset.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pcwr,
  output logic       irwr,
  output logic       turn,
  output logic [1:0] branch,
  output logic [1:0] jump,
  output logic       regwr,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       alusrc,
  output logic       extop,
  output logic [2:0] aluop,
  output logic       memrd,
  output logic       memwr,
  output logic       retire,
  output logic       illegal,
  output logic       timeout,
  output logic [3:0] state_o
);

  // Wait threshold clipped to what the 4-bit saturating counter can reach
  localparam logic [3:0] WAIT_MAX = (MEM_WAIT_MAX > 15) ? 4'hF : 4'(MEM_WAIT_MAX);

  logic [3:0]   r_state;
  logic [3:0]   r_wait_cnt;
  logic         r_timeout;
  logic [3:0]   w_next;
  logic [3:0]   w_cnt_inc;
  logic         w_waiting;
  instr_class_e w_class;

  logic       w_pcwr, w_irwr, w_turn, w_regwr, w_alusrc, w_extop;
  logic       w_memrd, w_memwr, w_illegal;
  logic [1:0] w_branch, w_jump, w_regdst, w_memtoreg;
  logic [2:0] w_aluop;

  mc_decode u_decode (
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_class  (w_class)
  );

  assign w_waiting = ((r_state == ST_MRD) || (r_state == ST_MWR)) && !mem_ready;
  assign w_cnt_inc = (r_wait_cnt == 4'hF) ? 4'hF : r_wait_cnt + 4'd1;

  // Next-state selection; unused encodings fall back to FETCH
  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: begin
        case (w_class)
          CL_R:         w_next = ST_EXE_R;
          CL_JR:        w_next = ST_JR;
          CL_ALUI:      w_next = ST_EXE_I;
          CL_LW, CL_SW: w_next = ST_MADDR;
          CL_BR:        w_next = ST_BR;
          CL_J, CL_JAL: w_next = ST_FETCH;
          default:      w_next = ST_ILL;
        endcase
      end
      ST_EXE_R:  w_next = ST_WB_R;
      ST_EXE_I:  w_next = ST_WB_I;
      ST_MADDR:  w_next = (w_class == CL_SW) ? ST_MWR : ST_MRD;
      ST_MRD:    w_next = mem_ready ? ST_WB_MEM : ST_MRD;
      ST_MWR:    w_next = mem_ready ? ST_FETCH : ST_MWR;
      default:   w_next = ST_FETCH;
    endcase
  end

  // Per-state datapath controls; a store retires in the cycle memory accepts it
  always_comb begin
    w_pcwr     = 1'b0;
    w_irwr     = 1'b0;
    w_turn     = 1'b0;
    w_branch   = BR_NONE;
    w_jump     = JP_NONE;
    w_regwr    = 1'b0;
    w_regdst   = 2'b00;
    w_memtoreg = 2'b00;
    w_alusrc   = 1'b0;
    w_extop    = 1'b0;
    w_aluop    = ALU_ADD;
    w_memrd    = 1'b0;
    w_memwr    = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_irwr = 1'b1;
        w_turn = 1'b1;
      end
      ST_DECODE: begin
        if (w_class == CL_J) begin
          w_pcwr = 1'b1;
          w_jump = JP_J;
        end else if (w_class == CL_JAL) begin
          w_pcwr     = 1'b1;
          w_jump     = JP_JAL;
          w_regwr    = 1'b1;
          w_regdst   = 2'b10;
          w_memtoreg = 2'b10;
        end
      end
      ST_EXE_R: w_aluop = alu_rtype(funct);
      ST_WB_R: begin
        w_regwr  = 1'b1;
        w_regdst = 2'b01;
        w_pcwr   = 1'b1;
      end
      ST_EXE_I, ST_WB_I: begin
        w_alusrc = 1'b1;
        w_extop  = (opcode == OP_ADDIU);
        w_aluop  = alu_itype(opcode);
        if (r_state == ST_WB_I) begin
          w_regwr = 1'b1;
          w_pcwr  = 1'b1;
        end
      end
      ST_MADDR, ST_MRD, ST_MWR: begin
        w_alusrc = 1'b1;
        w_extop  = 1'b1;
        w_memrd  = (r_state == ST_MRD);
        w_memwr  = (r_state == ST_MWR);
        w_pcwr   = (r_state == ST_MWR) && mem_ready;
      end
      ST_WB_MEM: begin
        w_regwr    = 1'b1;
        w_memtoreg = 2'b01;
        w_pcwr     = 1'b1;
      end
      ST_BR: begin
        w_aluop  = ALU_SUB;
        w_branch = branch_sel(opcode);
        w_pcwr   = 1'b1;
      end
      ST_JR: begin
        w_jump = JP_JR;
        w_pcwr = 1'b1;
      end
      ST_ILL: begin
        w_illegal = 1'b1;
        w_pcwr    = 1'b1;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next;
  end

  // Memory-wait counter (restarted from MADDR) and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
      r_timeout  <= 1'b0;
    end else if (r_state == ST_MADDR) begin
      r_wait_cnt <= 4'd0;
    end else if (w_waiting) begin
      r_wait_cnt <= w_cnt_inc;
      if (w_cnt_inc >= WAIT_MAX) r_timeout <= 1'b1;
    end
  end

  assign pcwr     = !rst && w_pcwr;
  assign retire   = !rst && w_pcwr;
  assign irwr     = !rst && w_irwr;
  assign turn     = !rst && w_turn;
  assign branch   = rst ? BR_NONE : w_branch;
  assign jump     = rst ? JP_NONE : w_jump;
  assign regwr    = !rst && w_regwr;
  assign regdst   = rst ? 2'b00 : w_regdst;
  assign memtoreg = rst ? 2'b00 : w_memtoreg;
  assign alusrc   = !rst && w_alusrc;
  assign extop    = !rst && w_extop;
  assign aluop    = rst ? ALU_ADD : w_aluop;
  assign memrd    = !rst && w_memrd;
  assign memwr    = !rst && w_memwr;
  assign illegal  = !rst && w_illegal;
  assign timeout  = !rst && r_timeout;
  assign state_o  = rst ? ST_FETCH : r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle control trace; one negedge process compares
// the DUT against that trace, and literal checks pin the model itself.
module tb_mc_ctrl;

  localparam int MAXW = 15;
  localparam int K_R = 0, K_JR = 1, K_ALUI = 2, K_LW = 3, K_SW = 4,
                 K_BR = 5, K_J = 6, K_JAL = 7, K_ILL = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic mem_ready = 1'b0;
  logic pcwr, irwr, turn, regwr, alusrc, extop, memrd, memwr, retire, illegal, timeout;
  logic [1:0] branch, jump, regdst, memtoreg;
  logic [2:0] aluop;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mc_ctrl #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pcwr(pcwr), .irwr(irwr), .turn(turn), .branch(branch), .jump(jump),
    .regwr(regwr), .regdst(regdst), .memtoreg(memtoreg), .alusrc(alusrc),
    .extop(extop), .aluop(aluop), .memrd(memrd), .memwr(memwr),
    .retire(retire), .illegal(illegal), .timeout(timeout), .state_o(state_o)
  );

  typedef struct packed {
    logic [3:0] state;
    logic       pcwr, irwr, turn;
    logic [1:0] branch, jump;
    logic       regwr;
    logic [1:0] regdst, memtoreg;
    logic       alusrc, extop;
    logic [2:0] aluop;
    logic       memrd, memwr, retire, illegal, timeout;
  } exp_t;

  typedef struct {
    exp_t e;
    bit   rdy;
  } cyc_t;

  exp_t chk_q[$];
  exp_t log_q[$];
  cyc_t tr_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_pcwr = 0;
  int   m_retired = 0;
  bit   m_to = 1'b0;
  exp_t a_c, e_c;

  logic [5:0] ops [12] = '{6'h00, 6'h00, 6'h09, 6'h0D, 6'h0F, 6'h23,
                           6'h2B, 6'h04, 6'h05, 6'h07, 6'h02, 6'h03};
  logic [5:0] fns [4]  = '{6'h21, 6'h23, 6'h2A, 6'h08};

  function automatic exp_t dut_now();
    exp_t a;
    a.state = state_o;  a.pcwr = pcwr;       a.irwr = irwr;     a.turn = turn;
    a.branch = branch;  a.jump = jump;       a.regwr = regwr;   a.regdst = regdst;
    a.memtoreg = memtoreg; a.alusrc = alusrc; a.extop = extop;  a.aluop = aluop;
    a.memrd = memrd;    a.memwr = memwr;     a.retire = retire; a.illegal = illegal;
    a.timeout = timeout;
    return a;
  endfunction

  function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
    int k;
    case (op)
      6'h00:               k = (fn == 6'h08) ? K_JR : K_R;
      6'h09, 6'h0D, 6'h0F: k = K_ALUI;
      6'h23:               k = K_LW;
      6'h2B:               k = K_SW;
      6'h04, 6'h05, 6'h07: k = K_BR;
      6'h02:               k = K_J;
      6'h03:               k = K_JAL;
      default:             k = K_ILL;
    endcase
    return k;
  endfunction

  // Append one expected cycle; retire always mirrors pcwr, timeout is the sticky model flag
  function automatic void add(input exp_t e, input bit rdy);
    cyc_t c;
    e.retire  = e.pcwr;
    e.timeout = m_to;
    c.e = e;
    c.rdy = rdy;
    tr_q.push_back(c);
  endfunction

  // Expand one instruction into its cycle-by-cycle expected controls
  function automatic void build(input logic [5:0] op, input logic [5:0] fn, input int waits);
    exp_t e;
    int   k;
    bit   is_lw;
    tr_q.delete();
    e = '0; e.irwr = 1'b1; e.turn = 1'b1;
    add(e, 1'($urandom_range(0, 1)));
    k = kind(op, fn);
    e = '0; e.state = 4'd1;
    if (k == K_J) begin
      e.pcwr = 1'b1; e.jump = 2'b01;
      add(e, 1'($urandom_range(0, 1)));
      return;
    end
    if (k == K_JAL) begin
      e.pcwr = 1'b1; e.jump = 2'b10; e.regwr = 1'b1; e.regdst = 2'b10; e.memtoreg = 2'b10;
      add(e, 1'($urandom_range(0, 1)));
      return;
    end
    add(e, 1'($urandom_range(0, 1)));
    e = '0;
    case (k)
      K_R: begin
        e.state = 4'd2;
        e.aluop = (fn == 6'h23) ? 3'b001 : (fn == 6'h2A) ? 3'b011 : 3'b000;
        add(e, 1'($urandom_range(0, 1)));
        e = '0; e.state = 4'd10; e.regwr = 1'b1; e.regdst = 2'b01; e.pcwr = 1'b1;
        add(e, 1'($urandom_range(0, 1)));
      end
      K_JR: begin
        e.state = 4'd9; e.jump = 2'b11; e.pcwr = 1'b1;
        add(e, 1'($urandom_range(0, 1)));
      end
      K_ALUI: begin
        e.alusrc = 1'b1;
        e.extop  = (op == 6'h09);
        e.aluop  = (op == 6'h0D) ? 3'b010 : (op == 6'h0F) ? 3'b100 : 3'b000;
        e.state  = 4'd3;
        add(e, 1'($urandom_range(0, 1)));
        e.state = 4'd11; e.regwr = 1'b1; e.pcwr = 1'b1;
        add(e, 1'($urandom_range(0, 1)));
      end
      K_LW, K_SW: begin
        is_lw = (k == K_LW);
        e.state = 4'd4; e.alusrc = 1'b1; e.extop = 1'b1;
        add(e, 1'($urandom_range(0, 1)));
        for (int i = 0; i <= waits; i++) begin
          e.state = is_lw ? 4'd5 : 4'd6;
          e.memrd = is_lw;
          e.memwr = !is_lw;
          e.pcwr  = !is_lw && (i == waits);
          add(e, i == waits);
          if (i < waits && i + 1 >= MAXW) m_to = 1'b1;
        end
        if (is_lw) begin
          e = '0; e.state = 4'd7; e.regwr = 1'b1; e.memtoreg = 2'b01; e.pcwr = 1'b1;
          add(e, 1'($urandom_range(0, 1)));
        end
      end
      K_BR: begin
        e.state = 4'd8; e.aluop = 3'b001; e.pcwr = 1'b1;
        e.branch = (op == 6'h04) ? 2'b01 : (op == 6'h05) ? 2'b10 : 2'b11;
        add(e, 1'($urandom_range(0, 1)));
      end
      default: begin
        e.state = 4'd12; e.illegal = 1'b1; e.pcwr = 1'b1;
        add(e, 1'($urandom_range(0, 1)));
      end
    endcase
  endfunction

  // Drive one instruction; abort<0 runs to completion, 0 resets at a random
  // point, >0 resets after that many cycles
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int waits, input int abort);
    int stop;
    build(op, fn, waits);
    stop = tr_q.size();
    if (abort == 0) stop = $urandom_range(1, tr_q.size() - 1);
    else if (abort > 0 && abort < tr_q.size()) stop = abort;
    for (int i = 0; i < stop; i++) begin
      @(posedge clk); #1;
      rst = 1'b0; opcode = op; funct = fn; mem_ready = tr_q[i].rdy;
      chk_q.push_back(tr_q[i].e);
    end
    if (stop == tr_q.size()) begin
      m_retired++;
    end else begin
      @(posedge clk); #1;
      rst = 1'b1; m_to = 1'b0; mem_ready = 1'($urandom_range(0, 1));
      chk_q.push_back(exp_t'(0));
    end
  endtask

  task automatic drain();
    @(negedge clk); #1;
  endtask

  task automatic lit(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic exp_t lg(input int i);
    if (i < log_q.size()) return log_q[i];
    return '1;
  endfunction

  function automatic int count_pcwr();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].pcwr) n++;
    return n;
  endfunction

  // Per-cycle comparison against the model trace
  always @(negedge clk) begin
    if (pcwr === 1'b1) n_pcwr++;
    if (chk_q.size() != 0) begin
      e_c = chk_q.pop_front();
      a_c = dut_now();
      total++;
      if (a_c !== e_c) begin
        bad++;
        $display("FAIL trace t=%0t got=%h want=%h (state got %0d want %0d)",
                 $time, a_c, e_c, a_c.state, e_c.state);
      end
      log_q.push_back(a_c);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int addu_st[4] = '{0, 1, 2, 10};
    int lw_st[8]   = '{0, 1, 4, 5, 5, 5, 5, 7};
    int n;
    logic [5:0] op, fn;
    int sel, waits;

    // Reset: all outputs low
    repeat (2) @(posedge clk);
    @(negedge clk);
    lit("reset_outputs", int'(dut_now()), 0);
    lit("reset_state", int'(state_o), 0);

    // addu
    log_q.delete(); run(6'h00, 6'h21, 0, -1); drain();
    lit("addu_len", log_q.size(), 4);
    for (int i = 0; i < 4; i++) lit("addu_state", int'(lg(i).state), addu_st[i]);
    lit("addu_pcwr_count", count_pcwr(), 1);
    lit("addu_wb_pcwr", int'(lg(3).pcwr), 1);
    lit("addu_wb_regwr", int'(lg(3).regwr), 1);
    lit("addu_wb_regdst", int'(lg(3).regdst), 1);

    // lw with 3 wait cycles
    log_q.delete(); run(6'h23, 6'h00, 3, -1); drain();
    lit("lw_len", log_q.size(), 8);
    for (int i = 0; i < 8; i++) lit("lw_state", int'(lg(i).state), lw_st[i]);
    n = 0; foreach (log_q[i]) if (log_q[i].memrd) n++;
    lit("lw_memrd_cycles", n, 4);
    lit("lw_pcwr_count", count_pcwr(), 1);
    lit("lw_wb_pcwr", int'(lg(7).pcwr), 1);
    lit("lw_wb_memtoreg", int'(lg(7).memtoreg), 1);

    // Branches
    log_q.delete(); run(6'h04, 6'h00, 0, -1); drain();
    lit("beq_state", int'(lg(2).state), 8);
    lit("beq_branch", int'(lg(2).branch), 1);
    lit("beq_pcwr", int'(lg(2).pcwr), 1);
    lit("beq_jump", int'(lg(2).jump), 0);
    log_q.delete(); run(6'h07, 6'h00, 0, -1); drain();
    lit("bgtz_branch", int'(lg(2).branch), 3);
    log_q.delete(); run(6'h05, 6'h00, 0, -1); drain();
    lit("bne_branch", int'(lg(2).branch), 2);

    // jal / jr
    log_q.delete(); run(6'h03, 6'h00, 0, -1); drain();
    lit("jal_len", log_q.size(), 2);
    lit("jal_pcwr", int'(lg(1).pcwr), 1);
    lit("jal_jump", int'(lg(1).jump), 2);
    lit("jal_regwr", int'(lg(1).regwr), 1);
    lit("jal_regdst", int'(lg(1).regdst), 2);
    lit("jal_memtoreg", int'(lg(1).memtoreg), 2);
    log_q.delete(); run(6'h00, 6'h08, 0, -1); drain();
    lit("jr_len", log_q.size(), 3);
    lit("jr_jump", int'(lg(2).jump), 3);

    // Illegal opcode
    log_q.delete(); run(6'h3F, 6'h15, 0, -1); drain();
    lit("ill_state", int'(lg(2).state), 12);
    lit("ill_flag", int'(lg(2).illegal), 1);
    lit("ill_pcwr", int'(lg(2).pcwr), 1);
    lit("ill_jump", int'(lg(2).jump), 0);

    // sw with 16 wait cycles raises a sticky timeout
    log_q.delete(); run(6'h2B, 6'h00, 16, -1); drain();
    n = 0; foreach (log_q[i]) if (log_q[i].memwr && !log_q[i].timeout) n++;
    lit("sw_cycles_before_timeout", n, 15);
    lit("sw_timeout_end", int'(lg(log_q.size() - 1).timeout), 1);
    lit("sw_pcwr_count", count_pcwr(), 1);
    log_q.delete(); run(6'h00, 6'h23, 0, -1); drain();
    lit("timeout_sticky", int'(lg(0).timeout), 1);

    // Reset during MRD: outputs drop immediately, no pcwr, fetch restarts
    log_q.delete(); run(6'h23, 6'h00, 5, 5); drain();
    lit("rst_mid_outputs", int'(lg(log_q.size() - 1)), 0);
    lit("rst_mid_pcwr", count_pcwr(), 0);
    lit("rst_mid_was_mrd", int'(lg(4).state), 5);
    log_q.delete(); run(6'h0D, 6'h00, 0, -1); drain();
    lit("after_rst_state", int'(lg(0).state), 0);
    lit("after_rst_irwr", int'(lg(0).irwr), 1);
    lit("after_rst_timeout", int'(lg(0).timeout), 0);

    // Randomized instruction stream
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 12);
      op = (sel < 12) ? ops[sel] : 6'($urandom);
      fn = ($urandom_range(0, 4) == 4) ? 6'($urandom) : fns[$urandom_range(0, 3)];
      waits = ($urandom_range(0, 39) == 0) ? 17 : $urandom_range(0, 3);
      run(op, fn, waits, ($urandom_range(0, 24) == 0) ? 0 : -1);
    end
    drain();
    lit("pcwr_per_instruction", n_pcwr, m_retired);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
